// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-port integer register file with a per-register pending-write scoreboard,
// two write ports (port 0 = ALU, port 1 = LSU) and a sequential bulk-clear engine.
//
// Parameters
//   XLEN      data width in bits
//   NREGS     number of registers (power of 2, >= 4)
//   NRD       number of read ports (1..4)
//   ZERO_REG  1: register 0 reads as 0, is never written and never busy
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   rd_addr/rd_data      packed read ports, port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   rd_busy              per read port: addressed register has an outstanding write
//   iss_valid, iss_rd    issue strobe marking iss_rd pending
//   we0/wa0/wd0          write port 0 (ALU)
//   we1/wa1/wd1          write port 1 (LSU), wins over port 0 on an address clash
//   clr_req              pulse starting the bulk clear of registers and scoreboard
//   ready                high in IDLE once out of reset; writes/issues/clr_req accepted
//
// Build option
//   REGFILE_BYPASS_EN    when defined, an accepted write is forwarded to matching
//                        read ports in the same cycle.

module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic                        iss_valid,
    input  logic [$clog2(NREGS)-1:0]    iss_rd,
    input  logic                        we0,
    input  logic [$clog2(NREGS)-1:0]    wa0,
    input  logic [XLEN-1:0]             wd0,
    input  logic                        we1,
    input  logic [$clog2(NREGS)-1:0]    wa1,
    input  logic [XLEN-1:0]             wd1,
    input  logic                        clr_req,
    output logic                        ready
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AW-1:0]       cnt;
    logic                init_done;
    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    wr0_hit;
    logic [NREGS-1:0]    wr1_hit;
    logic [NREGS-1:0]    iss_hit;

    // State register and clear counter. init_done keeps ready low for the
    // first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            init_done <= 1'b1;
            if (state == CLEAR) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Next-state logic: a clear runs exactly NREGS cycles, one register each.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req && init_done) state_next = CLEAR;
            CLEAR:   if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        ready = (state == IDLE) && init_done;
    end

    // Per-register decode of accepted writes and issues. Everything is gated
    // by ready so CLEAR and the post-reset cycle drop these requests.
    always_comb begin
        wr0_hit = '0;
        wr1_hit = '0;
        iss_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (!(ZERO_REG != 0 && r == 0)) begin
                wr0_hit[r] = ready && we0 && (wa0 == AW'(r));
                wr1_hit[r] = ready && we1 && (wa1 == AW'(r));
                iss_hit[r] = ready && iss_valid && (iss_rd == AW'(r));
            end
        end
    end

    // Register array and scoreboard. An issue outranks a same-cycle write for
    // the busy bit because the issued instruction is the newer producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
            busy[cnt] <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr1_hit[r]) begin
                    regs[r] <= wd1;
                end else if (wr0_hit[r]) begin
                    regs[r] <= wd0;
                end
                if (iss_hit[r]) begin
                    busy[r] <= 1'b1;
                end else if (wr0_hit[r] || wr1_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports, with optional same-cycle write forwarding.
    always_comb begin
        logic [AW-1:0]   addr_k;
        logic [XLEN-1:0] data_k;
        logic            busy_k;
        rd_data = '0;
        rd_busy = '0;
        addr_k  = '0;
        data_k  = '0;
        busy_k  = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            addr_k = rd_addr[k*AW +: AW];
            data_k = regs[addr_k];
            busy_k = busy[addr_k];
`ifdef REGFILE_BYPASS_EN
            if (ready && !(ZERO_REG != 0 && addr_k == '0)) begin
                if (we1 && (wa1 == addr_k)) begin
                    data_k = wd1;
                    busy_k = iss_valid && (iss_rd == addr_k);
                end else if (we0 && (wa0 == addr_k)) begin
                    data_k = wd0;
                    busy_k = iss_valid && (iss_rd == addr_k);
                end
            end
`endif
            if (ZERO_REG != 0 && addr_k == '0) begin
                data_k = '0;
                busy_k = 1'b0;
            end
            rd_data[k*XLEN +: XLEN] = data_k;
            rd_busy[k]              = busy_k;
        end
    end

endmodule
